// File: rtl/rx_frame_loader.sv
// UART byte stream to image RAM loader: sync header, raster-order pixel writes, idle timeout.
// Define CHECKSUM_EN to require a trailing mod-256 sum byte after the last pixel.
module rx_frame_loader #(
    parameter int unsigned IMG_W       = 64,
    parameter int unsigned IMG_H       = 64,
    parameter int unsigned ADDR_W      = 12,
    parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic              rx_drop,
    input  logic              img_ack
);

    localparam int unsigned       NumPix  = IMG_W * IMG_H;
    localparam int unsigned       TmoW    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NumPix - 1);
    localparam logic [TmoW-1:0]   TmoLast = TmoW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
`ifdef CHECKSUM_EN
        StCheck,
`endif
        StDone
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [TmoW-1:0]   tmo_cnt;
    logic              timing;
    logic              tmo_expired;
`ifdef CHECKSUM_EN
    logic [7:0]        sum;
`endif

    // The idle counter only runs while a frame is still expecting bytes.
    always_comb begin
        timing = (state == StLoad);
`ifdef CHECKSUM_EN
        timing = timing || (state == StCheck);
`endif
        tmo_expired = timing && !rx_valid && (tmo_cnt == TmoLast);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            pix_cnt    <= '0;
            tmo_cnt    <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rx_drop    <= 1'b0;
`ifdef CHECKSUM_EN
            sum        <= '0;
`endif
        end else begin
            mem_we     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            rx_drop    <= 1'b0;
            if (tmo_expired) begin
                frame_err <= 1'b1;
                busy      <= 1'b0;
                pix_cnt   <= '0;
                tmo_cnt   <= '0;
                state     <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state   <= StLoad;
                            busy    <= 1'b1;
                            pix_cnt <= '0;
                            tmo_cnt <= '0;
`ifdef CHECKSUM_EN
                            sum     <= '0;
`endif
                        end
                    end
                    StLoad: begin
                        if (rx_valid) begin
                            tmo_cnt   <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= pix_cnt;
                            mem_wdata <= rx_data;
                            pix_cnt   <= pix_cnt + 1'b1;
`ifdef CHECKSUM_EN
                            sum       <= sum + rx_data;
                            if (pix_cnt == LastPix) state <= StCheck;
`else
                            if (pix_cnt == LastPix) begin
                                frame_done <= 1'b1;
                                state      <= StDone;
                            end
`endif
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
`ifdef CHECKSUM_EN
                    StCheck: begin
                        if (rx_valid) begin
                            tmo_cnt <= '0;
                            state   <= StDone;
                            // A bad sum still hands the frame over; only the pulse differs.
                            if (rx_data == sum) frame_done <= 1'b1;
                            else                frame_err  <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
`endif
                    StDone: begin
                        if (rx_valid) rx_drop <= 1'b1;
                        if (img_ack) begin
                            state   <= StIdle;
                            busy    <= 1'b0;
                            pix_cnt <= '0;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
